// File: rtl/xbox_mm_feeder_if.sv
// Bus bundle between the matmul feeder and its surroundings: MEM0 port, matmul
// start/done pulses and the host CSR window.
interface xbox_mm_feeder_if #(
    parameter int LOG2_LINES_PER_MEM = 8
);
    // All signals are single-cycle strobes or level data sampled on posedge clk;
    // there is no valid/ready back-pressure: mem_rd returns data on the next cycle,
    // mm_start and mm_done are one-cycle pulses, host writes are one-cycle pulses.
    logic [LOG2_LINES_PER_MEM-1:0] mem_addr;
    logic [7:0][31:0]              mem_wdata;
    logic [31:0]                   mem_be;
    logic                          mem_rd;
    logic                          mem_wr;
    logic [7:0][31:0]              mem_rdata;
    logic                          mm_start;
    logic                          mm_done;
    logic [31:0][31:0]             host_regs;
    logic [31:0]                   host_regs_valid_pulse;
    logic [31:0][31:0]             host_regs_data_out;
    logic [31:0]                   host_regs_valid_out;

    modport master (
        output mem_addr, mem_wdata, mem_be, mem_rd, mem_wr, mm_start,
               host_regs_data_out, host_regs_valid_out,
        input  mem_rdata, mm_done, host_regs, host_regs_valid_pulse
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_be, mem_rd, mem_wr, mm_start,
               host_regs_data_out, host_regs_valid_out,
        output mem_rdata, mm_done, host_regs, host_regs_valid_pulse
    );
endinterface

// File: rtl/xbox_mm_feeder.sv
// Host-driven feeder: packs 2x2 operands into MEM0, kicks the matmul, waits for
// completion (with timeout) and reads the result back into the CSR window.
module xbox_mm_feeder #(
    parameter int                            LOG2_LINES_PER_MEM = 8,
    parameter logic [LOG2_LINES_PER_MEM-1:0] OPER_LINE          = 8'h00,
    parameter logic [LOG2_LINES_PER_MEM-1:0] RES_LINE           = 8'h01,
    parameter int                            TIMEOUT            = 64
) (
    input  logic                clk,
    input  logic                rst,
    xbox_mm_feeder_if.master    bus,
    output logic [2:0]          dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_KICK  = 3'd2,
        S_WAIT  = 3'd3,
        S_RDREQ = 3'd4,
        S_RDCAP = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t            state, state_nx;
    logic [7:0][31:0]  opnd;      // A11,A12,A21,A22,B11,B12,B21,B22
    logic [3:0][31:0]  c_reg;
    logic              done_reg;
    logic [2:0]        err_reg;
    logic [CW-1:0]     cnt;
    logic [31:0][31:0] rd_q;
    logic              go_pulse;
    logic              range_bad;
    logic              wait_expired;
    logic              unused_bits;

    assign go_pulse     = bus.host_regs_valid_pulse[0] && (bus.host_regs[0] == 32'd1);
    assign wait_expired = (cnt == CW'(TIMEOUT - 1));
    assign dbg_state    = state;
    assign unused_bits  = ^{bus.host_regs[31:12], bus.host_regs[3:1],
                            bus.host_regs_valid_pulse[31:1], bus.mem_rdata[7:4]};

    always_comb begin
        range_bad = 1'b0;
        for (int i = 4; i < 12; i++) begin
            if ($signed(bus.host_regs[i]) > 32'sd11 || $signed(bus.host_regs[i]) < -32'sd11)
                range_bad = 1'b1;
        end
    end

    // Next state and Moore outputs; outputs decode only the state register and
    // the operand snapshot, so mm_done never reaches mm_start combinationally.
    always_comb begin
        state_nx      = state;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mm_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (go_pulse && !range_bad) state_nx = S_WRITE;
            end
            S_WRITE: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = OPER_LINE;
                bus.mem_be    = 32'hFFFF_FFFF;
                bus.mem_wdata = opnd;
                state_nx      = S_KICK;
            end
            S_KICK: begin
                bus.mm_start = 1'b1;
                state_nx     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mm_done)       state_nx = S_RDREQ;
                else if (wait_expired) state_nx = S_IDLE;
            end
            S_RDREQ: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = RES_LINE;
                state_nx     = S_RDCAP;
            end
            S_RDCAP: state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            opnd     <= '0;
            c_reg    <= '0;
            done_reg <= 1'b0;
            err_reg  <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && go_pulse) begin
                done_reg <= 1'b0;
                err_reg  <= {2'b00, range_bad};
                opnd     <= bus.host_regs[11:4];
            end else if (state != S_IDLE && go_pulse) begin
                err_reg[1] <= 1'b1;
            end
            if (state == S_KICK) cnt <= '0;
            if (state == S_WAIT) begin
                cnt <= cnt + 1'b1;
                if (!bus.mm_done && wait_expired) err_reg[2] <= 1'b1;
            end
            if (state == S_RDCAP) c_reg <= bus.mem_rdata[3:0];
            if (state == S_FIN) done_reg <= 1'b1;
        end
    end

    // CSR read-back lags internal state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q        <= '0;
            rd_q[1]     <= {31'd0, state != S_IDLE};
            rd_q[2]     <= {31'd0, done_reg};
            rd_q[3]     <= {29'd0, err_reg};
            rd_q[15:12] <= c_reg;
        end
    end

    assign bus.host_regs_data_out  = rd_q;
    assign bus.host_regs_valid_out = {16'h0000, 4'hF, 8'h00, 1'b1, done_reg, 2'b10};

endmodule

// File: doc/xbox_mm_feeder.md
XBOX_MM_FEEDER -- requirements
Module: xbox_mm_feeder

Interface
REQ-001 SHALL have parameter LOG2_LINES_PER_MEM, default 8, meaning the memory address width.
REQ-002 SHALL have parameter OPER_LINE, default 8'h00, meaning the memory line that receives the packed operands.
REQ-003 SHALL have parameter RES_LINE, default 8'h01, meaning the memory line the matmul writes C to.
REQ-004 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for mm_done.
REQ-005 SHALL have port clk  in  1  system clock; one clock only, all logic on posedge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port mem_addr  out  LOG2_LINES_PER_MEM  MEM0 line address.
REQ-008 SHALL have port mem_wdata  out  [7:0][31:0]  MEM0 write data, 8 words.
REQ-009 SHALL have port mem_be  out  32  MEM0 byte enables.
REQ-010 SHALL have port mem_rd  out  1  MEM0 read strobe.
REQ-011 SHALL have port mem_wr  out  1  MEM0 write strobe.
REQ-012 SHALL have port mem_rdata  in  [7:0][31:0]  MEM0 read data, valid the cycle after mem_rd.
REQ-013 SHALL have port mm_start  out  1  single-cycle start pulse to the downstream 2x2 matmul.
REQ-014 SHALL have port mm_done  in  1  single-cycle completion pulse from the matmul.
REQ-015 SHALL have port host_regs  in  [31:0][31:0]  CSR contents as last written by SW.
REQ-016 SHALL have port host_regs_valid_pulse  in  32  per-register host write strobe.
REQ-017 SHALL have port host_regs_data_out  out  [31:0][31:0]  CSR values SW reads.
REQ-018 SHALL have port host_regs_valid_out  out  32  per-register read-valid.

Function
REQ-019 SHALL use this CSR map: 0 GO; 1 BUSY; 2 DONE; 3 ERR; 4-7 A11,A12,A21,A22; 8-11 B11,B12,B21,B22; 12-15 C11,C12,C21,C22 (read-back).
REQ-020 SHALL accept a GO when host_regs[0]==1, valid_pulse[0]==1 and state==IDLE; the accepted GO clears ERR and DONE.
REQ-021 SHALL snapshot regs 4-11 at GO acceptance and treat each as signed 32-bit.
REQ-022 SHALL treat any snapshot operand outside [-11,+11] as a range error: ERR[0]=1, no memory access, no mm_start, state stays IDLE.
REQ-023 SHALL use the states IDLE, WRITE, KICK, WAIT, RDREQ, RDCAP and FIN.
REQ-024 SHALL transition IDLE->WRITE when a GO is accepted and the range check passes.
REQ-025 SHALL, in WRITE (one cycle), drive mem_wr=1, mem_addr=OPER_LINE, mem_be=32'hFFFFFFFF, and mem_wdata words 0-3=A11,A12,A21,A22 and 4-7=B11,B12,B21,B22; next state KICK.
REQ-026 SHALL, in KICK (one cycle), drive mm_start=1, clear the timeout counter and go to WAIT.
REQ-027 SHALL, in WAIT, increment the counter each cycle; mm_done=1 -> RDREQ; counter reaching TIMEOUT-1 without mm_done -> ERR[2]=1, IDLE, no read-back.
REQ-028 SHALL give mm_done priority when it coincides with the timeout expiry cycle.
REQ-029 SHALL, in RDREQ, drive mem_rd=1 and mem_addr=RES_LINE; next state RDCAP.
REQ-030 SHALL, in RDCAP, capture mem_rdata words 0-3 into C11..C22 (regs 12-15); next state FIN.
REQ-031 SHALL, in FIN (one cycle), set DONE=1 (sticky until the next accepted GO); next state IDLE.
REQ-032 SHALL set BUSY=1 in all states except IDLE.
REQ-033 SHALL set ERR[1] (overrun) and ignore the GO when a GO pulse arrives while BUSY=1.
REQ-034 SHALL ignore mm_done outside WAIT.
REQ-035 SHALL make ERR bits sticky; bits [31:3] read 0.
REQ-036 SHALL register host_regs_data_out (one-cycle lag from internal state); registers other than 1, 2, 3 and 12-15 read 0.
REQ-037 SHALL drive host_regs_valid_out bits 1, 3 and 12-15 always 1; bit 2 = (DONE reg==1); all others 0.
REQ-038 SHALL hold mem_rd, mem_wr and mm_start at 0 and mem_addr, mem_be and mem_wdata at 0 in every state except where stated above.
REQ-039 SHALL drive host_regs, mem_rdata and mm_done from flop-synchronous logic only; no combinational path from mm_done to mm_start.
REQ-040 SHALL, from an undefined state encoding, go to IDLE.

Reset
REQ-041 SHALL, on rst=1 at a clk edge, set state=IDLE, counter=0, operand snapshot=0, C regs=0, DONE=0, ERR=0, host_regs_data_out=0 and all memory/mm outputs 0.
REQ-042 SHALL, on rst asserted mid-operation (any state), abandon the operation without a further mem_wr, mem_rd or mm_start.
REQ-043 SHALL ignore a GO pulse in the same cycle as rst.

Verification
REQ-044 SHALL cover: A=(1,2,3,4), B=(5,6,7,8), GO; model writes C=(19,22,43,50) to line 1 and pulses mm_done 4 cycles after mm_start -> exactly one mm_wr at line 0, one mm_start, regs 12-15=19,22,43,50, DONE=1, BUSY=0, ERR=0.
REQ-045 SHALL cover: A11=12, GO -> ERR=1, no mem_wr, no mm_start, BUSY stays 0.
REQ-046 SHALL cover: valid GO, model never asserts mm_done -> ERR=4 exactly TIMEOUT cycles after WAIT entry, no mem_rd, return to IDLE.
REQ-047 SHALL cover: second GO 2 cycles after the first -> ERR=2, first job completes normally, single mm_start.
REQ-048 SHALL cover: rst pulsed during WAIT, then a late mm_done -> all outputs 0, no read-back, next GO runs a full job normally.
REQ-049 SHALL cover: A=(-11,11,-1,0), B=(11,-11,0,1) -> write data sign-correct (32'hFFFFFFF5 etc.), result regs show model values.
